multdiv_unit: RTL and testbench
===============================

// Module: multdiv_unit
// PURPOSE
//   Iterative signed 32-bit multiplier/divider in the execute stage.
//   Consumes two operands read out of the register file and produces one
//   result plus an exception flag. The writeback path loads these into a
//   destination register (32-bit DFFE-based register) when data_resultRDY is
//   high.
//   Multi-cycle: one start pulse, fixed latency, one-cycle ready strobe.
// PARAMETERS
//   WIDTH      32  operand/result width; 32 is the only supported value.
//   CNT_BITS    6  iteration counter width; must hold WIDTH.
// PORTS
//   clk             in   1      rising-edge clock
//   clr             in   1      synchronous active-high reset
//   data_operandA   in   WIDTH  multiplicand / dividend (two's complement)
//   data_operandB   in   WIDTH  multiplier / divisor (two's complement)
//   ctrl_MULT       in   1      start multiply; operands sampled same edge
//   ctrl_DIV        in   1      start divide; operands sampled same edge
//   data_result     out  WIDTH  product low word / quotient, registered
//   data_exception  out  1      overflow or divide-by-zero, valid with RDY
//   data_resultRDY  out  1      one-cycle strobe: result/exception valid
//   busy            out  1      high in MULT and DIV states
// BEHAVIOUR
//   - clr (sampled at edge) -> state IDLE, counter 0, data_result 0,
//     data_exception 0, data_resultRDY 0, busy 0. Overrides every other input
//     and aborts any operation in flight; that operation produces no ready strobe.
//   - States: IDLE, MULT, DIV, DONE.
//     - Start in any state (IDLE, MULT, DIV, DONE): latch operands, counter := 0,
//       go to MULT or DIV.
//     - MULT/DIV: one iteration per edge, counter++.
//     - When counter reaches N: go to DONE.
//     - DONE: lasts exactly one cycle, then IDLE unless a start is present.
//   - Latency: start high in cycle 0 -> data_resultRDY high in cycle N+1 only.
//     - Multiply: N = 32.
//     - Divide: N = 32.
//   - data_result and data_exception update on the edge that enters DONE.
//     They hold until the next DONE or clr.
//   - Start while busy: the current operation is abandoned with no ready
//     strobe, and the new operation restarts at counter 0.
//   - ctrl_MULT and ctrl_DIV asserted together: multiply wins.
//   - Start during DONE: the strobe still occurs that cycle; the next edge
//     enters MULT/DIV.
//   - Multiply: radix-2 Booth on a 65-bit {P, A, q-1} accumulator; result =
//     low 32 bits of the 64-bit product.
//     - Overflow when the upper 33 product bits are not all equal:
//       data_exception = 1, low word still returned.
//   - Divide: restoring division on magnitudes.
//     - Quotient sign = signA ^ signB; truncate toward zero.
//     - Remainder is discarded.
//     - B == 0: result 0, exception 1, full N-cycle latency kept.
//     - A == 0x80000000 with B == -1: result 0x80000000, exception 1.
//   - Magnitude of 0x80000000 is taken as unsigned 2^31; no intermediate
//     overflow is allowed.
// CONFIGURATION
//   MULTDIV_BOOTH4_EN
//     - Defined: multiply uses radix-4 Booth, 2 bits per iteration.
//       Multiply N = 16, so RDY is in cycle 17. Divide is unchanged (N = 32).
//     - Undefined: radix-2 multiply as above, N = 32.
//     - Results and exceptions are bit-identical in both builds.
// TESTING
//   1. A=7, B=-3, ctrl_MULT in cycle 0 -> RDY in cycle 33 (17 with EN)
//      only; result 0xFFFFFFEB, exc 0.
//   2. A=0x00010000, B=0x00010000 MULT -> result 0x00000000, exc 1.
//      A=-1, B=-1 -> result 1, exc 0.
//   3. A=-100, B=7, ctrl_DIV in cycle 0 -> RDY in cycle 33; result
//      0xFFFFFFF2 (-14), exc 0.
//   4. A=5, B=0 DIV -> RDY in cycle 33, result 0, exc 1.
//      A=0x80000000, B=-1 -> result 0x80000000, exc 1.
//   5. MULT in cycle 0; ctrl_DIV A=9, B=2 in cycle 10 -> no RDY at 33;
//      RDY in cycle 43, result 4. Both ctrls in one cycle -> multiply result.
//   6. DIV started; clr in cycle 5 -> outputs 0, busy 0 next cycle, no RDY.
//      New MULT after clr -> normal latency.

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier (Booth) / restoring divider with fixed latency and a one-cycle ready strobe.
// Optional build macro: MULTDIV_BOOTH4_EN selects radix-4 Booth multiply (16 iterations instead of 32).
module multdiv_unit #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

`ifdef MULTDIV_BOOTH4_EN
  localparam logic [CNT_BITS-1:0] MULT_LAST = CNT_BITS'(WIDTH / 2 - 1);
`else
  localparam logic [CNT_BITS-1:0] MULT_LAST = CNT_BITS'(WIDTH - 1);
`endif
  localparam logic [CNT_BITS-1:0] DIV_LAST = CNT_BITS'(WIDTH - 1);
  localparam logic [WIDTH-1:0]    MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t              r_state;
  state_t              w_state_nx;
  logic [CNT_BITS-1:0] r_cnt;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic [WIDTH-1:0]    r_m;
  logic                r_qm1;
  logic                r_neg;
  logic                r_div_zero;
  logic                r_div_ovf;
  logic [WIDTH-1:0]    r_result;
  logic                r_exc;

  logic                w_start;
  logic                w_last;
  logic                w_busy;
  logic                w_rdy;
  logic [WIDTH-1:0]    w_hi_nx;
  logic [WIDTH-1:0]    w_lo_nx;
  logic                w_qm1_nx;
  logic [WIDTH-1:0]    w_res_nx;
  logic                w_exc_nx;
  logic [WIDTH-1:0]    w_abs_a;
  logic [WIDTH-1:0]    w_abs_b;
  logic [WIDTH:0]      w_shift;
  logic [WIDTH:0]      w_div_diff;
  logic [WIDTH:0]      w_top;
`ifdef MULTDIV_BOOTH4_EN
  logic [WIDTH+1:0]    w_p_ext;
  logic [WIDTH+1:0]    w_m_ext;
  logic [WIDTH+1:0]    w_m2_ext;
  logic [WIDTH+1:0]    w_sum;
`else
  logic [WIDTH:0]      w_p_ext;
  logic [WIDTH:0]      w_m_ext;
  logic [WIDTH:0]      w_sum;
`endif

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = ((r_state == S_MULT) && (r_cnt == MULT_LAST)) ||
                   ((r_state == S_DIV)  && (r_cnt == DIV_LAST));
  // Unsigned magnitudes: 0x80000000 maps to 2^31 without overflow
  assign w_abs_a = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign w_abs_b = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; a start pulse restarts from any state, multiply taking priority
  always_comb begin
    w_state_nx = S_IDLE;
    if (ctrl_MULT) begin
      w_state_nx = S_MULT;
    end else if (ctrl_DIV) begin
      w_state_nx = S_DIV;
    end else begin
      case (r_state)
        S_MULT:  w_state_nx = w_last ? S_DONE : S_MULT;
        S_DIV:   w_state_nx = w_last ? S_DONE : S_DIV;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the state register
  always_comb begin
    w_busy = 1'b0;
    w_rdy  = 1'b0;
    case (r_state)
      S_MULT:  w_busy = 1'b1;
      S_DIV:   w_busy = 1'b1;
      S_DONE:  w_rdy  = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // One iteration step: restoring divide or Booth multiply
  always_comb begin
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_qm1_nx   = r_qm1;
    w_shift    = {r_hi, r_lo[WIDTH-1]};
    w_div_diff = w_shift - {1'b0, r_m};
`ifdef MULTDIV_BOOTH4_EN
    w_p_ext  = {{2{r_hi[WIDTH-1]}}, r_hi};
    w_m_ext  = {{2{r_m[WIDTH-1]}}, r_m};
    w_m2_ext = {r_m[WIDTH-1], r_m, 1'b0};
    case ({r_lo[1:0], r_qm1})
      3'b001, 3'b010: w_sum = w_p_ext + w_m_ext;
      3'b011:         w_sum = w_p_ext + w_m2_ext;
      3'b100:         w_sum = w_p_ext - w_m2_ext;
      3'b101, 3'b110: w_sum = w_p_ext - w_m_ext;
      default:        w_sum = w_p_ext;
    endcase
`else
    w_p_ext = {r_hi[WIDTH-1], r_hi};
    w_m_ext = {r_m[WIDTH-1], r_m};
    case ({r_lo[0], r_qm1})
      2'b01:   w_sum = w_p_ext + w_m_ext;
      2'b10:   w_sum = w_p_ext - w_m_ext;
      default: w_sum = w_p_ext;
    endcase
`endif
    if (r_state == S_DIV) begin
      w_hi_nx  = w_div_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
      w_lo_nx  = {r_lo[WIDTH-2:0], ~w_div_diff[WIDTH]};
      w_qm1_nx = 1'b0;
    end else begin
`ifdef MULTDIV_BOOTH4_EN
      w_hi_nx  = w_sum[WIDTH+1:2];
      w_lo_nx  = {w_sum[1:0], r_lo[WIDTH-1:2]};
      w_qm1_nx = r_lo[1];
`else
      w_hi_nx  = w_sum[WIDTH:1];
      w_lo_nx  = {w_sum[0], r_lo[WIDTH-1:1]};
      w_qm1_nx = r_lo[0];
`endif
    end
  end

  // Final result and exception, meaningful on the last iteration
  always_comb begin
    w_top    = {w_hi_nx, w_lo_nx[WIDTH-1]};
    w_res_nx = w_lo_nx;
    w_exc_nx = 1'b0;
    if (r_state == S_DIV) begin
      if (r_div_zero) begin
        w_res_nx = '0;
        w_exc_nx = 1'b1;
      end else if (r_div_ovf) begin
        w_res_nx = MIN_VAL;
        w_exc_nx = 1'b1;
      end else begin
        w_res_nx = r_neg ? (~w_lo_nx + WIDTH'(1)) : w_lo_nx;
        w_exc_nx = 1'b0;
      end
    end else begin
      w_res_nx = w_lo_nx;
      w_exc_nx = ~((&w_top) | ~(|w_top));
    end
  end

  // Operand capture, iteration state and result registers
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_m        <= '0;
      r_qm1      <= 1'b0;
      r_neg      <= 1'b0;
      r_div_zero <= 1'b0;
      r_div_ovf  <= 1'b0;
      r_result   <= '0;
      r_exc      <= 1'b0;
    end else if (w_start) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_qm1      <= 1'b0;
      r_lo       <= ctrl_MULT ? data_operandB : w_abs_a;
      r_m        <= ctrl_MULT ? data_operandA : w_abs_b;
      r_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_div_zero <= (data_operandB == '0);
      r_div_ovf  <= (data_operandA == MIN_VAL) && (data_operandB == '1);
    end else if (w_busy) begin
      r_cnt <= r_cnt + CNT_BITS'(1);
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_qm1 <= w_qm1_nx;
      if (w_last) begin
        r_result <= w_res_nx;
        r_exc    <= w_exc_nx;
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = w_rdy;
  assign busy           = w_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus pushes model results with their due cycle,
// a negedge monitor pops and compares on every ready strobe.
`timescale 1ns/1ps
module tb_multdiv_unit;

`ifdef MULTDIV_BOOTH4_EN
  localparam int N_MULT = 16;
`else
  localparam int N_MULT = 32;
`endif
  localparam int N_DIV = 32;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        c_mult;
  logic        c_div;
  logic [31:0] res;
  logic        exc;
  logic        rdy;
  logic        busy_o;

  multdiv_unit #(.WIDTH(32), .CNT_BITS(6)) dut (
    .clk            (clk),
    .clr            (clr),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (c_mult),
    .ctrl_DIV       (c_div),
    .data_result    (res),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain signed 64-bit arithmetic
  function automatic void model(input logic is_mult, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    if (is_mult) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      p = longint'($signed(a)) / longint'($signed(b));
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Anything not yet strobed by cycle 'now' is abandoned by a restart or clr
  task automatic drop_after(input int now);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc > now) sb.delete(i);
    end
  endtask

  task automatic issue(input logic do_mult, input logic do_div, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] r;
    logic        x;
    drop_after(cyc);
    model(do_mult, a, b, r, x);
    e.res = r;
    e.exc = x;
    e.cyc = cyc + (do_mult ? N_MULT : N_DIV) + 1;
    sb.push_back(e);
    op_a   = a;
    op_b   = b;
    c_mult = do_mult;
    c_div  = do_div;
    step(1);
    c_mult = 1'b0;
    c_div  = 1'b0;
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
  endtask

  // Monitor: flag overdue expectations, then score each strobe
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL rdy_missing: no strobe in cycle %0d (now %0d)", e.cyc, cyc);
    end
    if (rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdy_unexpected: strobe in cycle %0d with nothing pending, result 0x%08h", cyc, res);
      end else begin
        e = sb.pop_front();
        check("rdy_cycle", 32'(cyc), 32'(e.cyc));
        check("result", res, e.res);
        check("exception", {31'd0, exc}, {31'd0, e.exc});
      end
    end
  end

  logic [31:0] edge_vals [5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'($urandom_range(0, 40)) - 32'd20;
      1:       v = edge_vals[$urandom_range(0, 4)];
      2:       v = 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int t;
    clr    = 1'b1;
    op_a   = 32'd0;
    op_b   = 32'd0;
    c_mult = 1'b0;
    c_div  = 1'b0;
    step(3);
    check("reset_result", res, 32'd0);
    check("reset_exc", {31'd0, exc}, 32'd0);
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    clr = 1'b0;
    step(2);

    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);          step(N_MULT + 2);
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);  step(N_MULT + 2);
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  step(N_MULT + 2);
    issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);  step(N_MULT + 2);
    issue(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);          step(N_DIV + 2);
    issue(1'b0, 1'b1, 32'd5, 32'd0);                  step(N_DIV + 2);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  step(N_DIV + 2);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'd1);          step(N_DIV + 2);

    // Restart while busy: only the second operation strobes
    issue(1'b1, 1'b0, 32'd3, 32'd4);
    step(9);
    issue(1'b0, 1'b1, 32'd9, 32'd2);
    step(N_DIV + 2);

    // Both controls together: multiply wins
    issue(1'b1, 1'b1, 32'd6, 32'd7);
    step(N_MULT + 2);

    // Start in the DONE cycle: first strobe still occurs
    issue(1'b1, 1'b0, 32'd11, 32'd13);
    step(N_MULT);
    issue(1'b0, 1'b1, 32'hFFFF_FFCE, 32'd3);
    step(N_DIV + 2);

    // clr during a divide aborts it and clears outputs
    issue(1'b0, 1'b1, 32'd1000, 32'd7);
    step(4);
    clr = 1'b1;
    drop_after(cyc);
    step(1);
    clr = 1'b0;
    check("clr_result", res, 32'd0);
    check("clr_exc", {31'd0, exc}, 32'd0);
    check("clr_busy", {31'd0, busy_o}, 32'd0);
    check("clr_rdy", {31'd0, rdy}, 32'd0);
    issue(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd9);
    step(N_MULT + 2);

    // Random operations with random gaps; short gaps exercise restart
    for (int i = 0; i < 60; i++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      issue(m, ~m, pick_operand(), pick_operand());
      step($urandom_range(0, 40));
    end

    t = 0;
    while (sb.size() > 0 && t < 100) begin
      step(1);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
